spi_flash_seq: RTL and testbench



---
 rtl/spi_flash_seq_pkg.sv | 28 ++
 rtl/spi_shift8.sv | 86 ++++++++
 rtl/spi_flash_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_flash_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_seq_pkg.sv
// Shared definitions for the SPI-flash read sequencer: FSM states, flash
// opcodes and the mode-0 idle levels of the SPI pins.
package spi_flash_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_HOLD = 3'd4,
    ST_GAP  = 3'd5,
    ST_RAW  = 3'd6
  } state_t;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam logic       SCK_IDLE       = 1'b0;
  localparam logic       MOSI_IDLE      = 1'b0;

  // Address byte idx of a 24-bit flash address, most significant first.
  function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
    case (idx)
      2'd0:    addr_byte = addr[23:16];
      2'd1:    addr_byte = addr[15:8];
      default: addr_byte = addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_shift8.sv
// Mode-0 MSB-first full-duplex byte shifter with a CLKDIV half-period prescaler.
// done is high in the last cycle of a byte so a new go can chain without a gap.
module spi_shift8
  import spi_flash_seq_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       go,
  input  logic       abort,
  input  logic [7:0] din,
  output logic       done,
  output logic [7:0] dout,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  logic       active_r;
  logic [7:0] div_cnt_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] tx_r;
  logic [7:0] rx_r;
  logic       sck_r;
  logic       mosi_r;
  logic       div_hit_s;
  logic       done_s;

  assign div_hit_s = (div_cnt_r == DIV_LAST);
  assign done_s    = active_r & div_hit_s & sck_r & (bit_cnt_r == 3'd7);
  assign done      = done_s;
  assign dout      = rx_r;
  assign sck       = sck_r;
  assign mosi      = mosi_r;

  // Prescaler, SCK phase, bit counter and shift registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      active_r  <= 1'b0;
      div_cnt_r <= 8'd0;
      bit_cnt_r <= 3'd0;
      tx_r      <= 8'h00;
      rx_r      <= 8'h00;
      sck_r     <= SCK_IDLE;
      mosi_r    <= MOSI_IDLE;
    end else if (abort) begin
      active_r  <= 1'b0;
      div_cnt_r <= 8'd0;
      bit_cnt_r <= 3'd0;
      sck_r     <= SCK_IDLE;
      mosi_r    <= MOSI_IDLE;
    end else if (go && (!active_r || done_s)) begin
      active_r  <= 1'b1;
      div_cnt_r <= 8'd0;
      bit_cnt_r <= 3'd0;
      tx_r      <= din;
      sck_r     <= SCK_IDLE;
      mosi_r    <= din[7];
    end else if (active_r) begin
      if (div_hit_s) begin
        div_cnt_r <= 8'd0;
        if (!sck_r) begin
          // MISO is captured on the edge that raises SCK.
          sck_r <= 1'b1;
          rx_r  <= {rx_r[6:0], miso};
        end else begin
          sck_r <= 1'b0;
          if (bit_cnt_r == 3'd7) begin
            active_r <= 1'b0;
            mosi_r   <= MOSI_IDLE;
          end else begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            tx_r      <= {tx_r[6:0], 1'b0};
            mosi_r    <= tx_r[6];
          end
        end
      end else begin
        div_cnt_r <= div_cnt_r + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spi_flash_seq.sv
// SPI-flash burst-read sequencer (READ + 24-bit address, N bytes out on a
// valid/ready port) plus a CPU raw byte mode with CPU-held chip select.
module spi_flash_seq
  import spi_flash_seq_pkg::*;
#(
  parameter int CLKDIV = 2,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             cmd_start,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  output logic             busy,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  input  logic             byte_ready,
  input  logic             raw_wr,
  input  logic [7:0]       raw_din,
  input  logic             raw_cs,
  output logic [7:0]       raw_dout,
  output logic             flash_sck,
  output logic             flash_mosi,
  input  logic             flash_miso,
  output logic             flash_csn
);

  localparam logic [8:0]       GAP_LAST = 9'(2 * CLKDIV - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           state_r;
  state_t           state_nx_s;
  logic [23:0]      addr_r;
  logic [LEN_W-1:0] len_r;
  logic [1:0]       idx_r;
  logic [8:0]       gap_cnt_r;
  logic             csn_r;
  logic             busy_r;
  logic             byte_valid_r;
  logic [7:0]       byte_data_r;
  logic [7:0]       raw_dout_r;
  logic             go_s;
  logic [7:0]       din_s;
  logic             load_s;
  logic             done_s;
  logic [7:0]       rx_s;
  logic             slot_free_s;

  spi_shift8 #(.CLKDIV(CLKDIV)) u_shift (
    .clk    (clk),
    .resetq (resetq),
    .go     (go_s),
    .abort  (cmd_abort),
    .din    (din_s),
    .done   (done_s),
    .dout   (rx_s),
    .sck    (flash_sck),
    .mosi   (flash_mosi),
    .miso   (flash_miso)
  );

  assign slot_free_s = !byte_valid_r || byte_ready;
  assign busy        = busy_r;
  assign byte_valid  = byte_valid_r;
  assign byte_data   = byte_data_r;
  assign raw_dout    = raw_dout_r;
  assign flash_csn   = csn_r;

  // Next-state, shifter launch and output-slot load decisions.
  always_comb begin
    state_nx_s = state_r;
    go_s       = 1'b0;
    din_s      = 8'h00;
    load_s     = 1'b0;
    if (cmd_abort) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_start) begin
            if (cmd_len != '0) begin
              state_nx_s = ST_CMD;
              go_s       = 1'b1;
              din_s      = FLASH_CMD_READ;
            end else begin
              state_nx_s = ST_IDLE;
            end
          end else if (raw_wr) begin
            state_nx_s = ST_RAW;
            go_s       = 1'b1;
            din_s      = raw_din;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (done_s) begin
            state_nx_s = ST_ADDR;
            go_s       = 1'b1;
            din_s      = addr_byte(addr_r, 2'd0);
          end else begin
            state_nx_s = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (done_s) begin
            go_s = 1'b1;
            if (idx_r == 2'd2) begin
              state_nx_s = ST_DATA;
            end else begin
              din_s = addr_byte(addr_r, idx_r + 2'd1);
            end
          end else begin
            state_nx_s = ST_ADDR;
          end
        end
        ST_DATA: begin
          // An unaccepted byte parks in the shifter until the slot frees up.
          if (done_s) begin
            if (slot_free_s) begin
              load_s = 1'b1;
              if (len_r == LEN_ONE) begin
                state_nx_s = ST_GAP;
              end else begin
                go_s = 1'b1;
              end
            end else begin
              state_nx_s = ST_HOLD;
            end
          end else begin
            state_nx_s = ST_DATA;
          end
        end
        ST_HOLD: begin
          if (byte_valid_r && byte_ready) begin
            load_s = 1'b1;
            if (len_r == LEN_ONE) begin
              state_nx_s = ST_GAP;
            end else begin
              state_nx_s = ST_DATA;
              go_s       = 1'b1;
            end
          end else begin
            state_nx_s = ST_HOLD;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_GAP;
          end
        end
        ST_RAW: begin
          if (done_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_RAW;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered handshake / pin outputs.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_r      <= ST_IDLE;
      addr_r       <= 24'h000000;
      len_r        <= '0;
      idx_r        <= 2'd0;
      gap_cnt_r    <= 9'd0;
      csn_r        <= 1'b1;
      busy_r       <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      raw_dout_r   <= 8'h00;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      if (cmd_abort) begin
        csn_r <= 1'b1;
      end else begin
        case (state_nx_s)
          ST_IDLE: csn_r <= ~raw_cs;
          ST_GAP:  csn_r <= 1'b1;
          default: csn_r <= 1'b0;
        endcase
      end
      if (state_r == ST_IDLE && state_nx_s == ST_CMD) begin
        addr_r <= cmd_addr;
        len_r  <= cmd_len;
      end else if (load_s) begin
        len_r <= len_r - LEN_ONE;
      end
      if (state_r == ST_CMD) begin
        idx_r <= 2'd0;
      end else if (state_r == ST_ADDR && done_s) begin
        idx_r <= idx_r + 2'd1;
      end
      if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + 9'd1;
      end else begin
        gap_cnt_r <= 9'd0;
      end
      if (cmd_abort) begin
        byte_valid_r <= 1'b0;
      end else if (load_s) begin
        byte_valid_r <= 1'b1;
        byte_data_r  <= rx_s;
      end else if (byte_valid_r && byte_ready) begin
        byte_valid_r <= 1'b0;
      end
      if (!cmd_abort && state_r == ST_RAW && done_s) begin
        raw_dout_r <= rx_s;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed bench for spi_flash_seq with a behavioural mode-0 flash model
// that logs MOSI bytes and returns a programmed response stream on MISO.
module tb_spi_flash_seq;

  logic        clk = 1'b0;
  logic        resetq;
  logic        cmd_start;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_abort;
  logic        busy;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        raw_wr;
  logic [7:0]  raw_din;
  logic        raw_cs;
  logic [7:0]  raw_dout;
  logic        flash_sck;
  logic        flash_mosi;
  logic        flash_miso;
  logic        flash_csn;

  always #5 clk = ~clk;

  spi_flash_seq #(.CLKDIV(2), .LEN_W(16)) dut (
    .clk        (clk),
    .resetq     (resetq),
    .cmd_start  (cmd_start),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_abort  (cmd_abort),
    .busy       (busy),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .raw_wr     (raw_wr),
    .raw_din    (raw_din),
    .raw_cs     (raw_cs),
    .raw_dout   (raw_dout),
    .flash_sck  (flash_sck),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso),
    .flash_csn  (flash_csn)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] resp [0:7];
  int         skip;
  logic [7:0] mosi_q [$];
  logic [7:0] got_q [$];
  int         got_t [$];
  int         cyc, csn_low_n, gap_n, busy_n, sck_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_bit(input int n);
    logic [7:0] b;
    int k;
    if (n < skip) return 1'b0;
    k = n - skip;
    if (k / 8 > 7) return 1'b0;
    b = resp[k / 8];
    return b[7 - (k % 8)];
  endfunction

  // Flash model and activity counters, sampled mid-cycle.
  initial begin
    int nbits;
    logic sck_prev;
    logic [7:0] mosi_sh;
    nbits = 0; sck_prev = 1'b0; mosi_sh = 8'h00;
    cyc = 0; csn_low_n = 0; gap_n = 0; busy_n = 0; sck_n = 0;
    flash_miso = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!flash_csn) csn_low_n++;
      if (flash_csn && busy) gap_n++;
      if (busy) busy_n++;
      if (byte_valid && byte_ready) begin
        got_q.push_back(byte_data);
        got_t.push_back(cyc);
      end
      if (flash_csn) begin
        nbits = 0;
        flash_miso = model_bit(0);
      end else if (flash_sck && !sck_prev) begin
        mosi_sh = {mosi_sh[6:0], flash_mosi};
        nbits++;
        sck_n++;
        if (nbits % 8 == 0) mosi_q.push_back(mosi_sh);
      end else if (!flash_sck && sck_prev) begin
        flash_miso = model_bit(nbits);
      end
      sck_prev = flash_sck;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_burst(input logic [23:0] a, input logic [15:0] l);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int i = 0;
    while (busy && i < max) begin
      step(1);
      i++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int m0, g0, c0, gp0, s0, b0, cy0, i;
    logic stable;
    logic [7:0] exp4 [0:3];
    cmd_start = 1'b0; cmd_addr = 24'h0; cmd_len = 16'd0; cmd_abort = 1'b0;
    byte_ready = 1'b1; raw_wr = 1'b0; raw_din = 8'h00; raw_cs = 1'b0;
    skip = 32;
    for (int k = 0; k < 8; k++) resp[k] = 8'h00;
    resetq = 1'b0;
    step(3);
    check("reset_vals", 32'({flash_csn, flash_sck, flash_mosi, busy, byte_valid, byte_data, raw_dout}), 32'h0010_0000);
    resetq = 1'b1;
    step(2);

    // Basic burst
    resp[0] = 8'hA5; resp[1] = 8'h5A; resp[2] = 8'hFF;
    m0 = mosi_q.size(); g0 = got_q.size(); c0 = csn_low_n; gp0 = gap_n;
    start_burst(24'h012345, 16'd3);
    wait_idle(2000, "burst_idle");
    check("burst_nmosi", 32'(mosi_q.size() - m0), 32'd7);
    check("burst_mosi0", 32'(mosi_q[m0]), 32'h03);
    check("burst_mosi1", 32'(mosi_q[m0+1]), 32'h01);
    check("burst_mosi2", 32'(mosi_q[m0+2]), 32'h23);
    check("burst_mosi3", 32'(mosi_q[m0+3]), 32'h45);
    check("burst_mosi_data", 32'(mosi_q[m0+4]), 32'h00);
    check("burst_nbytes", 32'(got_q.size() - g0), 32'd3);
    check("burst_b0", 32'(got_q[g0]), 32'hA5);
    check("burst_b1", 32'(got_q[g0+1]), 32'h5A);
    check("burst_b2", 32'(got_q[g0+2]), 32'hFF);
    check("burst_gap01", 32'(got_t[g0+1] - got_t[g0]), 32'd32);
    check("burst_gap12", 32'(got_t[g0+2] - got_t[g0+1]), 32'd32);
    check("burst_csn_low", 32'(csn_low_n - c0), 32'd224);
    check("burst_deselect", 32'(gap_n - gp0), 32'd4);

    // Backpressure
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    for (int k = 0; k < 4; k++) resp[k] = exp4[k];
    byte_ready = 1'b0;
    g0 = got_q.size(); s0 = sck_n;
    start_burst(24'h000400, 16'd4);
    i = 0;
    while (!byte_valid && i < 400) begin
      step(1);
      i++;
    end
    check("bp_valid", 32'(byte_valid), 32'd1);
    check("bp_first", 32'(byte_data), 32'h11);
    stable = 1'b1;
    repeat (100) begin
      step(1);
      if (byte_data !== 8'h11 || byte_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_sck_low", 32'(flash_sck), 32'd0);
    check("bp_sck_rises", 32'(sck_n - s0), 32'd48);
    check("bp_csn_low", 32'(flash_csn), 32'd0);
    byte_ready = 1'b1;
    wait_idle(2000, "bp_idle");
    step(2);
    check("bp_nbytes", 32'(got_q.size() - g0), 32'd4);
    for (int k = 0; k < 4; k++) check("bp_byte", 32'(got_q[g0+k]), 32'(exp4[k]));

    // Raw byte with CPU-held chip select
    skip = 0; resp[0] = 8'h02;
    raw_cs = 1'b1;
    step(3);
    check("raw_cs_low", 32'(flash_csn), 32'd0);
    s0 = sck_n; c0 = csn_low_n; cy0 = cyc; m0 = mosi_q.size();
    raw_din = 8'h05; raw_wr = 1'b1;
    step(1);
    raw_wr = 1'b0;
    wait_idle(200, "raw_idle");
    step(2);
    check("raw_dout", 32'(raw_dout), 32'h02);
    check("raw_sck_pulses", 32'(sck_n - s0), 32'd8);
    check("raw_mosi", 32'(mosi_q[m0]), 32'h05);
    check("raw_csn_hold", 32'(csn_low_n - c0), 32'(cyc - cy0));
    raw_cs = 1'b0;
    step(2);
    check("raw_cs_release", 32'(flash_csn), 32'd1);

    // Zero-length start is a no-op
    b0 = busy_n; s0 = sck_n; c0 = csn_low_n;
    start_burst(24'h000000, 16'd0);
    step(40);
    check("len0_busy", 32'(busy_n - b0), 32'd0);
    check("len0_sck", 32'(sck_n - s0), 32'd0);
    check("len0_csn", 32'(csn_low_n - c0), 32'd0);

    // raw_wr during a burst is ignored
    skip = 32; resp[0] = 8'h3C;
    m0 = mosi_q.size(); g0 = got_q.size();
    start_burst(24'hABCDEF, 16'd1);
    step(60);
    raw_din = 8'hFF; raw_wr = 1'b1;
    step(1);
    raw_wr = 1'b0;
    wait_idle(2000, "rawburst_idle");
    check("rawburst_nmosi", 32'(mosi_q.size() - m0), 32'd5);
    check("rawburst_mosi1", 32'(mosi_q[m0+1]), 32'hAB);
    check("rawburst_mosi2", 32'(mosi_q[m0+2]), 32'hCD);
    check("rawburst_mosi3", 32'(mosi_q[m0+3]), 32'hEF);
    check("rawburst_mosi4", 32'(mosi_q[m0+4]), 32'h00);
    check("rawburst_byte", 32'(got_q[g0]), 32'h3C);
    check("rawburst_rawdout", 32'(raw_dout), 32'h02);

    // Abort mid-address
    start_burst(24'h112233, 16'd2);
    step(70);
    check("abort_pre_busy", 32'(busy), 32'd1);
    cmd_abort = 1'b1;
    step(1);
    check("abort_outputs", 32'({flash_csn, flash_sck, busy, byte_valid}), 32'h8);
    cmd_abort = 1'b0;
    step(10);
    check("abort_stays_idle", 32'({flash_csn, busy}), 32'h2);

    // Asynchronous reset mid-data, then a clean burst
    resp[0] = 8'h77; resp[1] = 8'h88;
    byte_ready = 1'b0;
    start_burst(24'h000010, 16'd2);
    step(170);
    check("rst_pre_valid", 32'({busy, byte_valid}), 32'h3);
    #1 resetq = 1'b0;
    #1 check("rst_async_vals", 32'({flash_csn, flash_sck, flash_mosi, busy, byte_valid, byte_data, raw_dout}), 32'h0010_0000);
    step(2);
    resetq = 1'b1;
    byte_ready = 1'b1;
    resp[0] = 8'h81; resp[1] = 8'h7E;
    step(2);
    m0 = mosi_q.size(); g0 = got_q.size();
    start_burst(24'h000100, 16'd2);
    wait_idle(2000, "post_rst_idle");
    check("post_rst_mosi0", 32'(mosi_q[m0]), 32'h03);
    check("post_rst_mosi2", 32'(mosi_q[m0+2]), 32'h01);
    check("post_rst_nbytes", 32'(got_q.size() - g0), 32'd2);
    check("post_rst_b0", 32'(got_q[g0]), 32'h81);
    check("post_rst_b1", 32'(got_q[g0+1]), 32'h7E);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
